fb_pipectrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core.
- Drives the write-enable (we) and synchronous-flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use stalls, taken-branch flushes, instruction-fetch wait and multi-cycle data-memory wait, with a data-memory timeout.
- Sits beside the hazard/forwarding logic; its flush outputs are OR'ed with global rst at each pipeline register.

---
 rtl/fb_pipectrl_pkg.sv | 74 +++++++
 rtl/fb_loaduse_det.sv | 27 ++
 rtl/fb_pipectrl.sv | 154 +++++++++++++++
 tb/tb_fb_pipectrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pipectrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Control bundles are grouped per pipeline register for readability.
package fb_pipectrl_pkg;

  localparam int FB_32BITS = 32;
  localparam logic [4:0] FB_REG_ZERO = 5'd0;

  typedef enum logic {
    FB_PC_RUN     = 1'b0,
    FB_PC_MEMWAIT = 1'b1
  } fb_state_e;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } fb_stage_t;

  typedef struct packed {
    fb_stage_t we;
    fb_stage_t flush;
    logic      dmem_req;
  } fb_ctl_t;

  function automatic fb_ctl_t fb_ctl_default(
    input logic req
  );
    fb_ctl_t c;
    c.we       = 5'b11111;
    c.flush    = 5'b00000;
    c.dmem_req = req;
    return c;
  endfunction

  function automatic fb_ctl_t fb_ctl_reset();
    fb_ctl_t c;
    c.we       = 5'b00000;
    c.flush    = 5'b11111;
    c.dmem_req = 1'b0;
    return c;
  endfunction

  // Freeze PC..EX/MEM and bubble MEM/WB while data memory is busy.
  function automatic fb_ctl_t fb_ctl_stall(
    input logic req
  );
    fb_ctl_t c;
    c.we       = 5'b00001;
    c.flush    = 5'b00001;
    c.dmem_req = req;
    return c;
  endfunction

  function automatic fb_ctl_t fb_ctl_fetch(
    input fb_ctl_t c_in,
    input logic    lu_hit,
    input logic    imem_ready
  );
    fb_ctl_t c;
    c = c_in;
    if (lu_hit) begin
      c.we.pc      = 1'b0;
      c.we.ifid    = 1'b0;
      c.flush.idex = 1'b1;
    end else if (!imem_ready) begin
      c.we.pc      = 1'b0;
      c.flush.ifid = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/fb_loaduse_det.sv
// Load-use hazard compare between the ID operands and the EX load.
// Purely combinational; x0 never creates a hazard.
module fb_loaduse_det
  import fb_pipectrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_register_rd,
  output logic       hit
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 &
                   (id_rs1 == ex_register_rd);
  assign rs2_hit = id_use_rs2 &
                   (id_rs2 == ex_register_rd);

  assign hit = ex_mem_read &
               (ex_register_rd != FB_REG_ZERO) &
               (rs1_hit | rs2_hit);

endmodule

// File: rtl/fb_pipectrl.sv
// Pipeline sequencing controller: stalls, flushes, memory wait
// with timeout, and a saturating stall-cycle counter.
module fb_pipectrl
  import fb_pipectrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = FB_32BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_register_rd,
  input  logic             mem_mem_read,
  input  logic             mem_mem_write,
  input  logic             mem_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             dmem_req,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  fb_state_e  state;
  fb_state_e  state_nxt;
  logic [7:0] tmo_cnt;
  logic       lu_hit;
  logic       mem_op;
  logic       mem_stall;
  logic       run_branch;
  logic       tmo_hit;
  logic       in_wait;
  logic       forced;
  fb_ctl_t    ctl;

  fb_loaduse_det u_loaduse (
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_mem_read    (ex_mem_read),
    .ex_register_rd (ex_register_rd),
    .hit            (lu_hit)
  );

  assign mem_op     = mem_mem_read | mem_mem_write;
  assign mem_stall  = mem_op & ~dmem_ready;
  assign run_branch = mem_branch_taken & ~mem_stall;
  assign tmo_hit    = (tmo_cnt == 8'(MEM_TIMEOUT));
  assign in_wait    = (state == FB_PC_MEMWAIT);
  assign forced     = in_wait & ~dmem_ready & tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FB_PC_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FB_PC_RUN: begin
        if (mem_stall) state_nxt = FB_PC_MEMWAIT;
      end
      FB_PC_MEMWAIT: begin
        if (dmem_ready | tmo_hit) begin
          state_nxt = FB_PC_RUN;
        end
      end
      default: state_nxt = FB_PC_RUN;
    endcase
  end

  always_comb begin
    ctl = fb_ctl_default(mem_op);
    if (rst) begin
      ctl = fb_ctl_reset();
    end else if (!in_wait) begin
      unique case (1'b1)
        mem_stall: ctl = fb_ctl_stall(mem_op);
        run_branch: begin
          ctl.flush.ifid  = 1'b1;
          ctl.flush.idex  = 1'b1;
          ctl.flush.exmem = 1'b1;
        end
        default: ctl = fb_ctl_fetch(ctl, lu_hit, imem_ready);
      endcase
    end else begin
      unique case (1'b1)
        dmem_ready: ctl = fb_ctl_fetch(ctl, lu_hit, imem_ready);
        forced: begin
          // Failed access must not reach write-back.
          ctl.flush.memwb = 1'b1;
          ctl.dmem_req    = 1'b0;
        end
        default: ctl = fb_ctl_stall(mem_op);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= 8'd0;
    end else if (!in_wait) begin
      tmo_cnt <= mem_stall ? 8'd1 : 8'd0;
    end else if (dmem_ready | tmo_hit) begin
      tmo_cnt <= 8'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= forced;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!ctl.we.pc && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign pc_we       = ctl.we.pc;
  assign ifid_we     = ctl.we.ifid;
  assign idex_we     = ctl.we.idex;
  assign exmem_we    = ctl.we.exmem;
  assign memwb_we    = ctl.we.memwb;
  assign ifid_flush  = ctl.flush.ifid;
  assign idex_flush  = ctl.flush.idex;
  assign exmem_flush = ctl.flush.exmem;
  assign memwb_flush = ctl.flush.memwb;
  assign dmem_req    = ctl.dmem_req;

endmodule

// File: tb/tb_fb_pipectrl.sv
// Bench for fb_pipectrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_fb_pipectrl;

  localparam int T = 4;

  localparam logic [9:0] P_RST    = 10'b00000_1111_0;
  localparam logic [9:0] P_IDLE   = 10'b11111_0000_0;
  localparam logic [9:0] P_LU     = 10'b00111_0100_0;
  localparam logic [9:0] P_BR     = 10'b11111_1110_0;
  localparam logic [9:0] P_STALL  = 10'b00001_0001_1;
  localparam logic [9:0] P_REL    = 10'b11111_0000_1;
  localparam logic [9:0] P_FORCED = 10'b11111_0001_0;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_register_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read;
  logic        mem_mem_read, mem_mem_write, mem_branch_taken;
  logic        imem_ready, dmem_ready;
  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        dmem_req, bus_err;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  bit          m_wait;
  int          m_n;
  bit          m_bus;
  logic [31:0] m_stall;

  always #5 clk = ~clk;

  fb_pipectrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_register_rd(ex_register_rd),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_branch_taken(mem_branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .dmem_req(dmem_req), .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  wire [9:0] dut_ctl = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                        ifid_flush, idex_flush, exmem_flush,
                        memwb_flush, dmem_req};

  // Bit order: pc,ifid,idex,exmem,memwb we | same flushes | dmem_req
  function automatic logic [9:0] model_ctl();
    logic memop, lu;
    logic [9:0] c;
    memop = mem_mem_read | mem_mem_write;
    lu = ex_mem_read && ex_register_rd != 5'd0 &&
         ((id_use_rs1 && id_rs1 == ex_register_rd) ||
          (id_use_rs2 && id_rs2 == ex_register_rd));
    if (rst) return P_RST;
    c = {9'b11111_0000, memop};
    if (m_wait && !dmem_ready) begin
      if (m_n == T) return P_FORCED;
      return {9'b00001_0001, memop};
    end
    if (!m_wait && memop && !dmem_ready) return {9'b00001_0001, memop};
    if (!m_wait && mem_branch_taken) return {9'b11111_1110, memop};
    if (lu) begin
      c[9] = 1'b0; c[8] = 1'b0; c[3] = 1'b1;
    end else if (!imem_ready) begin
      c[9] = 1'b0; c[4] = 1'b1;
    end
    return c;
  endfunction

  always @(posedge clk) begin : model
    logic [9:0] c;
    c = model_ctl();
    if (rst) begin
      m_wait = 0; m_n = 0; m_bus = 0; m_stall = '0;
    end else begin
      m_bus = m_wait && !dmem_ready && m_n == T;
      if (!c[9] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (m_wait) begin
        if (dmem_ready || m_n == T) begin
          m_wait = 0; m_n = 0;
        end else begin
          m_n = m_n + 1;
        end
      end else if ((mem_mem_read || mem_mem_write) && !dmem_ready) begin
        m_wait = 1; m_n = 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ctl", {22'd0, dut_ctl}, {22'd0, model_ctl()});
      check("model_stall_cnt", stall_cnt, m_stall);
      check("model_bus_err", {31'd0, bus_err}, {31'd0, m_bus});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; ex_register_rd = 0; mem_mem_read = 0;
    mem_mem_write = 0; mem_branch_taken = 0;
    imem_ready = 1; dmem_ready = 1;
  endtask

  task automatic rand_in();
    id_rs1 = 5'($urandom_range(3));
    id_rs2 = 5'($urandom_range(3));
    id_use_rs1 = 1'($urandom);
    id_use_rs2 = 1'($urandom);
    ex_mem_read = 1'($urandom);
    ex_register_rd = 5'($urandom_range(3));
    mem_mem_read = ($urandom_range(9) < 2);
    mem_mem_write = ($urandom_range(9) < 1);
    mem_branch_taken = ($urandom_range(9) < 2);
    imem_ready = ($urandom_range(9) < 8);
    dmem_ready = ($urandom_range(9) < 4);
  endtask

  initial begin
    idle();
    rand_in();
    rst = 1;
    tick();
    chk_en = 1;
    @(negedge clk);
    check("reset_ctl", {22'd0, dut_ctl}, {22'd0, P_RST});
    check("reset_cnt", stall_cnt, 32'd0);
    tick(); rand_in(); rst = 1;
    @(negedge clk);
    check("reset_ctl2", {22'd0, dut_ctl}, {22'd0, P_RST});
    tick(); idle();
    @(negedge clk);
    check("after_reset", {22'd0, dut_ctl}, {22'd0, P_IDLE});
    check("after_reset_cnt", stall_cnt, 32'd0);

    tick();
    ex_mem_read = 1; ex_register_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    @(negedge clk);
    check("loaduse", {22'd0, dut_ctl}, {22'd0, P_LU});
    tick(); ex_register_rd = 0; id_rs2 = 0;
    @(negedge clk);
    check("loaduse_cnt", stall_cnt, 32'd1);
    check("rd_zero", {22'd0, dut_ctl}, {22'd0, P_IDLE});

    tick(); ex_register_rd = 5; id_rs2 = 5; mem_branch_taken = 1;
    @(negedge clk);
    check("branch_lu", {22'd0, dut_ctl}, {22'd0, P_BR});
    tick(); idle();
    @(negedge clk);
    check("branch_cnt", stall_cnt, 32'd1);

    tick(); mem_mem_read = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("memwait", {22'd0, dut_ctl}, {22'd0, P_STALL});
      tick();
    end
    dmem_ready = 1;
    @(negedge clk);
    check("mem_release", {22'd0, dut_ctl}, {22'd0, P_REL});
    tick(); idle();
    @(negedge clk);
    check("memwait_cnt", stall_cnt, 32'd4);

    tick(); mem_mem_write = 1; dmem_ready = 0;
    for (int i = 0; i < T; i++) begin
      @(negedge clk);
      check("tmo_wait", {22'd0, dut_ctl}, {22'd0, P_STALL});
      tick();
    end
    @(negedge clk);
    check("forced", {22'd0, dut_ctl}, {22'd0, P_FORCED});
    check("bus_err_pre", {31'd0, bus_err}, 32'd0);
    tick(); idle();
    @(negedge clk);
    check("bus_err_pulse", {31'd0, bus_err}, 32'd1);
    check("run_after_tmo", {22'd0, dut_ctl}, {22'd0, P_IDLE});
    tick();
    @(negedge clk);
    check("bus_err_clear", {31'd0, bus_err}, 32'd0);

    tick(); mem_mem_write = 1; dmem_ready = 0;
    for (int i = 0; i < T; i++) begin
      @(negedge clk);
      tick();
    end
    dmem_ready = 1;
    @(negedge clk);
    check("ready_at_tmo", {22'd0, dut_ctl}, {22'd0, P_REL});
    tick(); idle();
    @(negedge clk);
    check("ready_no_err", {31'd0, bus_err}, 32'd0);

    tick(); mem_mem_read = 1; dmem_ready = 0;
    tick(); tick(); rst = 1;
    @(negedge clk);
    check("rst_in_wait", {22'd0, dut_ctl}, {22'd0, P_RST});
    tick(); rst = 0;
    @(negedge clk);
    check("rst_wait_cnt", stall_cnt, 32'd0);
    for (int i = 1; i < T; i++) begin
      tick();
      @(negedge clk);
      check("rerun_wait", {22'd0, dut_ctl}, {22'd0, P_STALL});
    end
    tick();
    @(negedge clk);
    check("rerun_forced", {22'd0, dut_ctl}, {22'd0, P_FORCED});
    tick(); idle();

    for (int i = 0; i < 3000; i++) begin
      tick();
      rand_in();
      rst = ($urandom_range(99) == 0);
    end
    tick(); idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
